// File: rtl/match_window_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_window_counter: counts detector match pulses per programmable window |
// | and reports each window's count/alarm on a valid/ready port.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module match_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             det_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_alarm,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIN_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_thresh, w_thresh_nxt;
  logic [CNT_W-1:0] w_final;
  logic             w_start;
  logic             w_cand;
  logic             w_cand_alarm;
  logic             w_xfer;

  logic             r_rpt_valid;
  logic [CNT_W-1:0] r_rpt_count;
  logic             r_rpt_alarm;
  logic             r_overrun;

  assign w_start      = enable && (win_len != '0);
  // Count including this cycle's pulse; this is the final count on the last cycle.
  assign w_final      = (det_in && (r_count != c_cnt_max)) ? r_count + CNT_W'(1'b1) : r_count;
  assign w_cand_alarm = (w_final >= r_thresh);
  assign w_xfer       = r_rpt_valid && rpt_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_count_nxt  = r_count;
    w_thresh_nxt = r_thresh;
    w_cand       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt  = S_COUNT;
          w_timer_nxt  = win_len - WIN_W'(1'b1);
          w_thresh_nxt = threshold;
          w_count_nxt  = '0;
        end
      end
      S_COUNT: begin
        // Abort wins over completion: partial window is silently discarded.
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == '0) begin
          w_cand = 1'b1;
          if (w_start) begin
            w_timer_nxt  = win_len - WIN_W'(1'b1);
            w_thresh_nxt = threshold;
            w_count_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_count_nxt = w_final;
          w_timer_nxt = r_timer - WIN_W'(1'b1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_count  <= '0;
      r_thresh <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_count  <= w_count_nxt;
      r_thresh <= w_thresh_nxt;
    end
  end

  // Report register: loads when empty or draining this cycle, else drops and flags overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_valid <= 1'b0;
      r_rpt_count <= '0;
      r_rpt_alarm <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_cand && (!r_rpt_valid || w_xfer)) begin
      r_rpt_valid <= 1'b1;
      r_rpt_count <= w_final;
      r_rpt_alarm <= w_cand_alarm;
    end else begin
      if (w_cand) begin
        r_overrun <= 1'b1;
      end
      if (w_xfer) begin
        r_rpt_valid <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == S_COUNT);
  assign rpt_valid = r_rpt_valid;
  assign rpt_count = r_rpt_count;
  assign rpt_alarm = r_rpt_alarm;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/match_window_counter.md
# match_window_counter

Downstream consumer of the serial 101-pattern detector's single-cycle match output. Counts match pulses over a programmable window of clock cycles, compares the total against a threshold, and presents each window's result on a valid/ready report port. Windows run back-to-back while enabled, so a monitoring or CSR stage can read per-window match rates without losing cycles.

## Interface
- CNT_W, default 8: width of the match counter and report count; counts saturate at 2^CNT_W-1.
- WIN_W, default 16: width of the window-length input and the internal cycle timer.

- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run windows while high.
- det_in  in  1  match pulse from the detector; every cycle it is high counts as one match.
- win_len  in  WIN_W  window length in cycles; sampled only at window start.
- threshold  in  CNT_W  alarm threshold; sampled at window start.
- busy  out  1  high while in COUNT.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts the report.
- rpt_count  out  CNT_W  matches counted in the reported window.
- rpt_alarm  out  1  rpt_count >= threshold latched for that window.
- overrun  out  1  sticky flag: a finished window's report was dropped.

## Operation
- FSM states: IDLE and COUNT. The report register is independent of the FSM.
- IDLE -> COUNT:
  - Taken when enable=1 and win_len!=0.
  - Latch win_len into timer as win_len-1, latch threshold, clear the match count.
  - If win_len==0, the block stays in IDLE.
- COUNT, each cycle:
  - If det_in=1, increment the count, saturating at 2^CNT_W-1.
  - If timer!=0, decrement it.
- COUNT, last cycle (timer==0):
  - The final count includes this cycle's det_in.
  - Report candidate: count = final count, alarm = (final count >= latched threshold). threshold=0 always gives alarm=1.
  - If enable=1 and win_len!=0, restart immediately with fresh latches and stay in COUNT. Otherwise go to IDLE.
- enable=0 during COUNT: abort. Go to IDLE next edge, discard the partial count, and produce no report. Abort takes priority over window completion in the same cycle.
- Report handshake:
  - Transfer occurs on a cycle with rpt_valid & rpt_ready.
  - While rpt_valid=1 and no transfer, rpt_count and rpt_alarm hold stable.
  - New candidate with rpt_valid=0, or with a transfer in the same cycle: load the register, and rpt_valid is 1 next cycle. No overrun.
  - New candidate with rpt_valid=1 and no transfer: drop the candidate, keep the old report, set overrun. overrun clears only on reset.
- Reset in any state:
  - Next cycle: IDLE, busy=0, rpt_valid=0, rpt_count=0, rpt_alarm=0, overrun=0.
  - Any in-flight window and any pending report are discarded.

## Timing
- enable sampled high at edge k in IDLE: busy=1 from cycle k+1. The window covers det_in in cycles k+1 .. k+win_len.
- Report visible (rpt_valid=1) in cycle k+win_len+1, one cycle after the window ends.
- Back-to-back windows have no gap. Window n+1 covers cycles k+win_len+1 .. k+2*win_len.
- Abort: busy=0 the cycle after enable is sampled low.
- rpt_valid falls the cycle after a transfer, unless a new report loads on that same edge.
- Throughput: one report per win_len cycles. With win_len=1, one report per cycle, and rpt_ready must be held high to avoid overrun.

## Test plan
- Reset: hold reset for 2 cycles mid-window with a pending report -> busy=0, rpt_valid=0, rpt_count=0, rpt_alarm=0, overrun=0 on the next cycle.
- Basic window: win_len=8, threshold=2, det_in=1 in window cycles 3, 5, 7, rpt_ready=1 -> rpt_valid for 1 cycle at k+9, rpt_count=3, rpt_alarm=1. The same run with threshold=4 -> rpt_alarm=0.
- Saturation: CNT_W=8, win_len=300, det_in held at 1 -> rpt_count=255, rpt_alarm=1 for threshold=255.
- Backpressure and overrun: win_len=4, rpt_ready=0 for 3 windows with 1, 2, 3 matches -> rpt_count stays 1, overrun=1 after window 2. Then assert rpt_ready -> transfer of 1, rpt_valid=0 afterwards.
- Simultaneous accept and load: win_len=1, rpt_ready=1, det_in alternating 1,0,1 -> rpt_valid high continuously, rpt_count sequence 1,0,1, overrun=0.
- Abort and zero length: drop enable at window cycle 3 of 8 -> busy=0 next cycle, no report. Set win_len=0 with enable=1 -> busy stays 0 and no report is produced.
